// File: rtl/slant_pkg.sv
// Shared constants and elaboration-time helpers for the slant frame store.
package slant_pkg;

    localparam int Y_LSB  = 0;
    localparam int Y_MSB  = 7;
    localparam int CB_LSB = 8;
    localparam int CB_MSB = 15;
    localparam int CR_LSB = 16;
    localparam int CR_MSB = 23;

    localparam int H_ACT_DEF    = 640;
    localparam int V_ACT_DEF    = 480;
    localparam int DEC_LOG2_DEF = 1;
    localparam int NBANK_DEF    = 4;
    localparam int CW_DEF       = 5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < v) r = i + 1;
            else r = r;
        end
        return r;
    endfunction

    function automatic int w_s_f(input int h_act, input int dec_log2);
        return h_act >> dec_log2;
    endfunction

    function automatic int depth_f(input int h_act, input int v_act, input int dec_log2, input int nbank);
        return ((h_act >> dec_log2) * (v_act >> dec_log2)) / nbank;
    endfunction

    localparam int W_S   = w_s_f(H_ACT_DEF, DEC_LOG2_DEF);
    localparam int DEPTH = depth_f(H_ACT_DEF, V_ACT_DEF, DEC_LOG2_DEF, NBANK_DEF);

endpackage

// File: rtl/slant_frame_buf_if.sv
// AXI4-Stream video beat bundle; master is the camera side, slave is the frame store.
interface slant_frame_buf_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/slant_bank_ram.sv
// One slant bank: simple dual-port RAM, synchronous write, registered read.
module slant_bank_ram #(
    parameter int WIDTH   = 10,
    parameter int ENTRIES = 32,
    parameter int AW      = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [ENTRIES];

    // write port and registered read port
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/slant_frame_buf.sv
// Decimating ping-pong frame store: camera stream in, upscaled raster pixels out.
module slant_frame_buf
    import slant_pkg::*;
#(
    parameter int H_ACT    = H_ACT_DEF,
    parameter int V_ACT    = V_ACT_DEF,
    parameter int DEC_LOG2 = DEC_LOG2_DEF,
    parameter int NBANK    = NBANK_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NBANK-1:0]   bank_en,
    slant_frame_buf_if.slave   s_axis_video,
    input  logic               rd_frame_start,
    input  logic               rd_en,
    output logic [23:0]        rd_data,
    output logic               rd_valid,
    output logic               frame_ready,
    output logic               wr_frame_done,
    output logic [15:0]        drop_cnt
);
    localparam int LW_S   = w_s_f(H_ACT, DEC_LOG2);
    localparam int LDEPTH = depth_f(H_ACT, V_ACT, DEC_LOG2, NBANK);
    localparam int AW     = clog2(2 * LDEPTH);
    localparam int SW     = clog2(LW_S * (V_ACT >> DEC_LOG2));
    localparam int BW     = clog2(NBANK);
    localparam int XW     = clog2(H_ACT + 1);
    localparam int YW     = clog2(V_ACT + 1);
    localparam logic [XW-1:0] XMASK = XW'((1 << DEC_LOG2) - 1);
    localparam logic [YW-1:0] YMASK = YW'((1 << DEC_LOG2) - 1);

    logic [XW-1:0] wx_q, wx_d, ex_s, rx_q, rx_d, cx_s;
    logic [YW-1:0] wy_q, wy_d, ey_s, ry_q, ry_d, cy_s;
    logic          wr_act_q, wr_act_d, act_s, beat_s, keep_s, done_s, drop_s, swap_s, rwrap_s;
    logic          full_q, wb_q, rb_q, rb_d, frame_ready_q, frame_ready_d, done_q;
    logic [15:0]   drop_cnt_q;
    logic [SW-1:0] si_s, ri_s;
    logic          wr_en_q, rv1_q, force1_q, rd_valid_q;
    logic [BW-1:0] wr_bank_q, rbank_s, rbank1_q, cb_bank_s, cr_bank_s;
    logic [AW-1:0] wr_addr_q, waddr_s, raddr_s;
    logic [2*CW-1:0] wr_data_q, wdata_s;
    logic [2*CW-1:0] rdata_s [NBANK];
    logic [23:0]   rd_data_q, rd_data_d;
    logic          unused_tdata_s;

    assign s_axis_video.tready = 1'b1;
    assign unused_tdata_s      = ^s_axis_video.tdata;

    // effective write coordinates: a tuser beat restarts the frame at (0,0)
    always_comb begin
        if (s_axis_video.tuser) begin
            ex_s  = '0;
            ey_s  = '0;
            act_s = !full_q;
        end else begin
            ex_s  = wx_q;
            ey_s  = wy_q;
            act_s = wr_act_q;
        end
    end

    assign beat_s  = s_axis_video.tvalid;
    assign keep_s  = beat_s && act_s && (ex_s < XW'(H_ACT)) && (ey_s < YW'(V_ACT))
                     && ((ex_s & XMASK) == '0) && ((ey_s & YMASK) == '0);
    assign done_s  = beat_s && act_s && s_axis_video.tlast && (ey_s == YW'(V_ACT - 1));
    assign drop_s  = beat_s && s_axis_video.tuser && full_q;
    assign swap_s  = rd_frame_start && full_q;
    assign si_s    = SW'((int'(ey_s) >> DEC_LOG2) * LW_S + (int'(ex_s) >> DEC_LOG2));
    assign waddr_s = AW'(int'(wb_q) * LDEPTH + int'(si_s >> BW));
    assign wdata_s = {s_axis_video.tdata[Y_MSB -: CW],
                      si_s[0] ? s_axis_video.tdata[CR_MSB -: CW] : s_axis_video.tdata[CB_MSB -: CW]};

    // write counter next state; counters saturate past the active area
    always_comb begin
        wx_d     = wx_q;
        wy_d     = wy_q;
        wr_act_d = wr_act_q;
        if (beat_s) begin
            if (s_axis_video.tlast) begin
                wx_d = '0;
                wy_d = (ey_s < YW'(V_ACT)) ? ey_s + YW'(1) : ey_s;
            end else begin
                wx_d = (ex_s < XW'(H_ACT)) ? ex_s + XW'(1) : ex_s;
                wy_d = ey_s;
            end
            wr_act_d = done_s ? 1'b0 : act_s;
        end else begin
            wr_act_d = wr_act_q;
        end
    end

    assign rb_d          = swap_s ? ~rb_q : rb_q;
    assign frame_ready_d = swap_s ? 1'b1 : frame_ready_q;

    // read counters: a frame-start pulse rewinds before this cycle's fetch
    always_comb begin
        cx_s    = rd_frame_start ? '0 : rx_q;
        cy_s    = rd_frame_start ? '0 : ry_q;
        rwrap_s = (cx_s == XW'(H_ACT - 1));
        rx_d    = rd_en ? (rwrap_s ? '0 : cx_s + XW'(1)) : cx_s;
        ry_d    = (rd_en && rwrap_s) ? ((cy_s == YW'(V_ACT - 1)) ? '0 : cy_s + YW'(1)) : cy_s;
    end

    assign ri_s    = SW'((int'(cy_s) >> DEC_LOG2) * LW_S + (int'(cx_s) >> DEC_LOG2));
    assign rbank_s = ri_s[BW-1:0];
    assign raddr_s = AW'(int'(rb_d) * LDEPTH + int'(ri_s >> BW));

    // reassemble Y from the pixel's bank and the chroma pair from its even/odd neighbours
    always_comb begin
        cb_bank_s = rbank1_q & ~BW'(1);
        cr_bank_s = rbank1_q | BW'(1);
        rd_data_d = '0;
        if (force1_q) begin
            rd_data_d = '0;
        end else begin
            rd_data_d[Y_MSB:Y_LSB]   = 8'(rdata_s[rbank1_q][2*CW-1:CW]) << (8 - CW);
            rd_data_d[CB_MSB:CB_LSB] = 8'(rdata_s[cb_bank_s][CW-1:0]) << (8 - CW);
            rd_data_d[CR_MSB:CR_LSB] = 8'(rdata_s[cr_bank_s][CW-1:0]) << (8 - CW);
        end
    end

    // all control state, write pipeline and read pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            wx_q <= '0; wy_q <= '0; wr_act_q <= 1'b0;
            full_q <= 1'b0; wb_q <= 1'b0; rb_q <= 1'b1; frame_ready_q <= 1'b0;
            drop_cnt_q <= 16'd0; done_q <= 1'b0;
            wr_en_q <= 1'b0; wr_bank_q <= '0; wr_addr_q <= '0; wr_data_q <= '0;
            rx_q <= '0; ry_q <= '0; rv1_q <= 1'b0; rbank1_q <= '0; force1_q <= 1'b1;
            rd_valid_q <= 1'b0; rd_data_q <= 24'd0;
        end else begin
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            wr_act_q <= wr_act_d;
            full_q   <= done_s ? 1'b1 : (swap_s ? 1'b0 : full_q);
            wb_q     <= swap_s ? ~wb_q : wb_q;
            rb_q     <= rb_d;
            frame_ready_q <= frame_ready_d;
            drop_cnt_q <= (drop_s && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
            done_q    <= done_s;
            wr_en_q   <= keep_s;
            wr_bank_q <= si_s[BW-1:0];
            wr_addr_q <= waddr_s;
            wr_data_q <= wdata_s;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            rv1_q     <= rd_en;
            rbank1_q  <= rbank_s;
            force1_q  <= !frame_ready_d || !bank_en[rbank_s];
            rd_valid_q <= rv1_q;
            rd_data_q  <= rd_data_d;
        end
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        slant_bank_ram #(.WIDTH(2 * CW), .ENTRIES(2 * LDEPTH), .AW(AW)) u_ram (
            .clk     (clk),
            .we_i    (wr_en_q && (wr_bank_q == BW'(g))),
            .waddr_i (wr_addr_q),
            .wdata_i (wr_data_q),
            .raddr_i (raddr_s),
            .rdata_o (rdata_s[g])
        );
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign frame_ready   = frame_ready_q;
    assign wr_frame_done = done_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_slant_frame_buf.sv
// Directed self-checking bench for slant_frame_buf at 16x8, decimation 2, 4 banks, 5-bit components.
module tb_slant_frame_buf;
    localparam int H = 16;
    localparam int V = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  bank_en;
    logic        rd_frame_start, rd_en;
    logic [23:0] rd_data;
    logic        rd_valid, frame_ready, wr_frame_done;
    logic [15:0] drop_cnt;
    logic [23:0] img [H*V];
    int          n_cmp = 0;
    int          n_err = 0;
    int          nd;

    always #5 clk = ~clk;

    slant_frame_buf_if vif ();

    slant_frame_buf #(.H_ACT(H), .V_ACT(V), .DEC_LOG2(1), .NBANK(4), .CW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .bank_en        (bank_en),
        .s_axis_video   (vif),
        .rd_frame_start (rd_frame_start),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .frame_ready    (frame_ready),
        .wr_frame_done  (wr_frame_done),
        .drop_cnt       (drop_cnt)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // expected output: nearest stored sample is the even-aligned source pixel, 5 MSBs kept
    function automatic logic [23:0] exp_pix(input int x, input int y, input int yoff,
                                            input logic [7:0] cb, input logic [7:0] cr,
                                            input logic [3:0] en);
        int sx;
        int sy;
        logic [7:0] yv;
        sx = (x >> 1) << 1;
        sy = (y >> 1) << 1;
        yv = 8'(yoff + sx + 16 * sy);
        if (!en[(x >> 1) % 4]) return 24'h000000;
        return {cr & 8'hF8, cb & 8'hF8, yv & 8'hF8};
    endfunction

    task automatic read_frame(input logic pulse, input int yoff, input logic [7:0] cb,
                              input logic [7:0] cr, input logic [3:0] en, input string tag);
        int got;
        got = 0;
        for (int n = 0; n < 131; n++) begin
            @(negedge clk);
            chk($sformatf("%s rd_valid@%0d", tag, n), 24'(rd_valid), 24'(n >= 2 && n <= 129));
            if (rd_valid && got < H * V) begin
                chk($sformatf("%s px(%0d,%0d)", tag, got % H, got / H), rd_data,
                    exp_pix(got % H, got / H, yoff, cb, cr, en));
                img[got] = rd_data;
                got++;
            end
            rd_frame_start = pulse && (n == 0);
            rd_en          = (n < 128);
        end
        rd_en = 1'b0;
        chk({tag, " count"}, 24'(got), 24'(H * V));
    endtask

    task automatic send_frame(input int yoff, input logic [7:0] cb, input logic [7:0] cr,
                              input int nlines, input logic fs_last, output int ndone);
        ndone = 0;
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < H; x++) begin
                @(negedge clk);
                ndone += int'(wr_frame_done);
                vif.tvalid     = 1'b1;
                vif.tuser      = (x == 0 && y == 0);
                vif.tlast      = (x == H - 1);
                vif.tdata      = {cr, cb, 8'(yoff + x + 16 * y)};
                rd_frame_start = fs_last && (y == nlines - 1) && (x == H - 1);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ndone += int'(wr_frame_done);
            vif.tvalid = 1'b0; vif.tuser = 1'b0; vif.tlast = 1'b0; rd_frame_start = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bank_en = 4'b1111; rd_frame_start = 1'b0; rd_en = 1'b0;
        vif.tvalid = 1'b0; vif.tuser = 1'b0; vif.tlast = 1'b0; vif.tdata = 24'd0;
        repeat (4) @(negedge clk);
        chk("reset tready",        24'(vif.tready),      24'd1);
        chk("reset rd_data",       rd_data,              24'd0);
        chk("reset rd_valid",      24'(rd_valid),        24'd0);
        chk("reset frame_ready",   24'(frame_ready),     24'd0);
        chk("reset wr_frame_done", 24'(wr_frame_done),   24'd0);
        chk("reset drop_cnt",      24'(drop_cnt),        24'd0);
        rst = 1'b0;

        // no frame written yet: everything reads zero
        read_frame(1'b1, 0, 8'h00, 8'h00, 4'b0000, "blank");
        chk("blank frame_ready", 24'(frame_ready), 24'd0);

        send_frame(0, 8'hA0, 8'h50, V, 1'b0, nd);
        chk("frameA done pulses", 24'(nd), 24'd1);
        read_frame(1'b1, 0, 8'hA0, 8'h50, 4'b1111, "frameA");
        chk("frameA frame_ready", 24'(frame_ready), 24'd1);
        chk("frameA px(2,2)", img[2*H+2], 24'h50A020);
        chk("frameA px(3,2)", img[2*H+3], 24'h50A020);
        chk("frameA px(2,3)", img[3*H+2], 24'h50A020);
        chk("frameA px(3,3)", img[3*H+3], 24'h50A020);

        // second frame lands while the first is unread: it is dropped
        send_frame(128, 8'h30, 8'hC8, V, 1'b0, nd);
        chk("frameB done pulses", 24'(nd), 24'd1);
        send_frame(64, 8'h11, 8'h22, V, 1'b0, nd);
        chk("frameC done pulses", 24'(nd), 24'd0);
        chk("drop_cnt after C", 24'(drop_cnt), 24'd1);
        read_frame(1'b1, 128, 8'h30, 8'hC8, 4'b1111, "frameB");
        chk("drop_cnt after read", 24'(drop_cnt), 24'd1);

        bank_en = 4'b1101;
        read_frame(1'b1, 128, 8'h30, 8'hC8, 4'b1101, "masked");
        bank_en = 4'b1111;

        // frame aborted after 5 lines by a fresh tuser, then a complete frame
        send_frame(32, 8'h44, 8'h66, 5, 1'b0, nd);
        chk("aborted done pulses", 24'(nd), 24'd0);
        send_frame(96, 8'h88, 8'h22, V, 1'b0, nd);
        chk("frameE done pulses", 24'(nd), 24'd1);
        read_frame(1'b1, 96, 8'h88, 8'h22, 4'b1111, "frameE");

        // completion coincident with rd_frame_start: old frame stays until next pulse
        send_frame(16, 8'hB8, 8'h48, V, 1'b1, nd);
        chk("frameF done pulses", 24'(nd), 24'd1);
        chk("frameF frame_ready", 24'(frame_ready), 24'd1);
        read_frame(1'b0, 96, 8'h88, 8'h22, 4'b1111, "noSwap");
        read_frame(1'b1, 16, 8'hB8, 8'h48, 4'b1111, "swapF");
        chk("swapF frame_ready", 24'(frame_ready), 24'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/slant_frame_buf.md
# slant_frame_buf

Parametrised, single-clock successor to the camera-side slant frame store. It accepts an AXI4-Stream 24-bit YCbCr 4:4:4 camera stream and decimates it by 2^DEC_LOG2 in x and y. It stores reduced-precision 4:2:2 samples interleaved across NBANK banks, in a ping-pong pair of frame buffers. A pixel-request read port returns the last complete frame, upscaled back to H_ACT×V_ACT, for the HDMI/colour-conversion path.

## Interface
- H_ACT, 640, active pixels per input line and per output line.
- V_ACT, 480, active lines per frame.
- DEC_LOG2, 1, log2 decimation factor. Legal values are 0..2.
- NBANK, 4, number of slant banks. Must be a power of 2 and ≥2. (H_ACT>>DEC_LOG2) must be a multiple of NBANK.
- CW, 5, stored bits per component. These are the MSBs of each 8-bit input component.
- Cclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- bank_en  in  NBANK  per-bank output enable. A pixel sourced from a disabled bank reads as 24'h000000.
- s_axis_video_tdata  in  24  {Cr[23:16], Cb[15:8], Y[7:0]}.
- s_axis_video_tvalid  in  1  input beat valid.
- s_axis_video_tuser  in  1  start of frame.
- s_axis_video_tlast  in  1  end of line.
- s_axis_video_tready  out  1  constant 1; the block never back-pressures.
- rd_frame_start  in  1  pulse; begins an output frame and requests a buffer swap.
- rd_en  in  1  request one output pixel (raster order).
- rd_data  out  24  {Cr,Cb,Y}, each component = stored CW bits followed by (8-CW) zeros.
- rd_valid  out  1  rd_data qualifier.
- frame_ready  out  1  the read buffer holds a complete frame.
- wr_frame_done  out  1  one-cycle pulse when a frame finishes writing.
- drop_cnt  out  16  count of frames discarded, saturating.

## Operation
- Write counters:
  - wx counts 0..H_ACT-1 per beat; wy counts 0..V_ACT-1 per tlast.
  - A beat with tuser forces wx=0, wy=0 for that beat. This aborts any partial frame without completion.
  - Beats with wx≥H_ACT are ignored. Lines with wy≥V_ACT are ignored.
- Keep rule: a beat is stored iff wx[DEC_LOG2-1:0]==0 and wy[DEC_LOG2-1:0]==0.
- Stored index: si = (wy>>DEC_LOG2)*W_S + (wx>>DEC_LOG2), where W_S = H_ACT>>DEC_LOG2.
  - Bank = si mod NBANK.
  - Address = buf*DEPTH + si/NBANK, where DEPTH = W_S*(V_ACT>>DEC_LOG2)/NBANK.
- Each bank stores Y[7:8-CW] and a chroma sample C. C = Cb if si even, Cr if si odd.
- Completion: tlast on line wy==V_ACT-1 sets full and pulses wr_frame_done.
  - While full=1, whole input frames are discarded. They are counted into drop_cnt at their tuser beat.
- Buffers: wb is the write buffer and rb the read buffer (1 bit each); reset wb=0, rb=1, full=0.
- On rd_frame_start:
  - If full=1 (registered value): swap wb/rb, clear full, set frame_ready=1.
  - In every case, reset rx=ry=0.
- Read counters advance per rd_en: rx wraps at H_ACT and increments ry; ry wraps at V_ACT to 0.
- Read index: ri = (ry>>DEC_LOG2)*W_S + (rx>>DEC_LOG2).
  - All banks are read at address rb*DEPTH + ri/NBANK.
  - Y comes from bank ri mod NBANK.
  - Cb comes from bank (ri mod NBANK)&~1; Cr comes from bank (ri mod NBANK)|1.
- Output forcing: rd_data=0 when frame_ready=0 or bank_en[ri mod NBANK]=0.

## Timing
- Write: accepted beat at cycle t is written to RAM at edge t+1 (one register stage).
- Read: rd_en at cycle t gives rd_valid=1 and rd_data at t+2 (address register, then RAM output register).
- rd_frame_start and rd_en in the same cycle: the counters reset first, and that rd_en fetches pixel (0,0).
- Completion and rd_frame_start in the same cycle: no swap, because the registered full is still 0. The swap waits for the next rd_frame_start.
- Reset values: s_axis_video_tready=1, rd_data=0, rd_valid=0, frame_ready=0, wr_frame_done=0, drop_cnt=0. All counters are 0.
- Reset mid-frame discards the partial frame. RAM contents are not cleared.
- Short line (early tlast): the remaining stored positions of that line keep their old contents.

## Structure
- Shared package slant_pkg holds:
  - component bit offsets (Y 7:0, Cb 15:8, Cr 23:16);
  - a clog2 function;
  - the localparams W_S and DEPTH.
- Sub-module slant_bank_ram: single-clock simple dual-port RAM with a registered read.
  - Width 2*CW, depth 2*DEPTH.
  - NBANK instances are generated.

## Test plan
All scenarios use H_ACT=16, V_ACT=8, DEC_LOG2=1, NBANK=4, CW=5.
- Reset, then rd_frame_start, then 128 rd_en: rd_data=0 throughout, frame_ready=0, rd_valid follows rd_en delayed 2 cycles.
- One frame with Y=x+16*y, Cb=8'hA0, Cr=8'h50, then rd_frame_start:
  - wr_frame_done pulses once and frame_ready=1.
  - Pixel (3,2) returns Y=8'h20 (source pixel (2,2)=34 → CW bits 00100 → 8'h20), Cb=8'hA0, Cr=8'h50.
  - Pixels (2,2), (3,2), (2,3) and (3,3) return identical data.
- Two frames sent without rd_frame_start: second frame dropped, drop_cnt=1. Readback after rd_frame_start shows frame 1.
- bank_en=4'b1101: every output pixel with (rx>>1) mod 4 == 1 reads 0; all other pixels are unchanged.
- tuser reasserted on line 5 of a frame: no wr_frame_done. The next full frame completes normally.
- Completion coincident with rd_frame_start: no swap on that pulse; the next rd_frame_start swaps and frame_ready=1.
